// File: rtl/bcd_arb_pkg.sv
// Shared state encoding and constants for the BCD converter arbiter.
package bcd_arb_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 64;
    localparam int unsigned DefaultNumReq        = 4;
    localparam int unsigned DefaultIdWidth       = $clog2(DefaultNumReq);

    // Index width for a requester count; never below one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping upward.
module rr_priority_picker
    import bcd_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefaultNumReq,
    parameter int unsigned ID_W    = DefaultIdWidth
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] sel_onehot,
    output logic [ID_W-1:0]    sel_idx,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                sel_idx         = idx;
                sel_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NUM_REQ requesters.
// Define BCD_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with an error after TIMEOUT_CYCLES.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_DIGS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [4*NUM_DIGS-1:0]         resp_digs,
    output logic                          resp_err,
    output logic                          conv_en,
    output logic [DATA_WIDTH-1:0]         conv_din,
    input  logic [4*NUM_DIGS-1:0]         conv_digs,
    input  logic                          conv_done
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    if (NUM_REQ < 2) begin : g_chk_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e              state_q, state_d;
    logic [IdW-1:0]          ptr_q, ptr_d;
    logic [IdW-1:0]          cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    conv_en_q, conv_en_d;
    logic [DATA_WIDTH-1:0]   conv_din_q, conv_din_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [IdW-1:0]          resp_id_q, resp_id_d;
    logic [4*NUM_DIGS-1:0]   resp_digs_q, resp_digs_d;
    logic [IdW-1:0]          next_ptr;

    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IdW-1:0]          pick_idx;
    logic                    pick_any;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IdW)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .sel_onehot (pick_onehot),
        .sel_idx    (pick_idx),
        .any        (pick_any)
    );

    assign next_ptr = (cur_id_q == IdW'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            resp_err_q, resp_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_id_d     = cur_id_q;
        gnt_d        = '0;
        conv_en_d    = 1'b0;
        conv_din_d   = conv_din_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_digs_d  = resp_digs_q;
`ifdef BCD_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        resp_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // conv_done seen here is stale and deliberately ignored.
                if (pick_any) begin
                    gnt_d     = pick_onehot;
                    conv_en_d = 1'b1;
                    cur_id_d  = pick_idx;
                    state_d   = StWait;
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (pick_onehot[i]) begin
                            conv_din_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
`ifdef BCD_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            StWait: begin
                if (conv_done) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = cur_id_q;
                    resp_digs_d  = conv_digs;
                    ptr_d        = next_ptr;
                    state_d      = StIdle;
`ifdef BCD_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_id_d    = cur_id_q;
                    resp_digs_d  = '1;
                    ptr_d        = next_ptr;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cur_id_q     <= '0;
            gnt_q        <= '0;
            conv_en_q    <= 1'b0;
            conv_din_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_digs_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_id_q     <= cur_id_d;
            gnt_q        <= gnt_d;
            conv_en_q    <= conv_en_d;
            conv_din_q   <= conv_din_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_digs_q  <= resp_digs_d;
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign conv_en    = conv_en_q;
    assign conv_din   = conv_din_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_digs  = resp_digs_q;

endmodule
